parallel_to_serial_tx: RTL and testbench

Parallel-to-serial transmitter: accepts N-bit words over a valid/ready handshake and shifts them out one bit per clock, LSB first. It sits directly upstream of the serial-to-parallel receiver, whose bit counter free-runs from reset. A one-word holding register plus a same-cycle bypass let back-to-back words stream with no idle bit between frames. Frame markers and an underrun pulse let the system keep the receiver's framing aligned.

---
 rtl/parallel_to_serial_tx_if.sv | 24 ++
 rtl/parallel_to_serial_tx.sv | 71 +++++++
 tb/tb_parallel_to_serial_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/parallel_to_serial_tx_if.sv
// Load handshake and serial output bundle for parallel_to_serial_tx.
// The master drives words in; the slave (the transmitter) drives the serial side.
interface parallel_to_serial_tx_if #(
    parameter int N = 8
);
    logic [N-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         sdata;
    logic         svalid;
    logic         frame_start;
    logic         frame_last;
    logic         underrun_tick;

    modport master (
        output load_data, load_valid,
        input  load_ready, sdata, svalid, frame_start, frame_last, underrun_tick
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, sdata, svalid, frame_start, frame_last, underrun_tick
    );
endinterface

// File: rtl/parallel_to_serial_tx.sv
// Parallel-to-serial transmitter: one shifting word plus a one-word holding register,
// with same-cycle bypass on the last bit so consecutive frames stream gap-free.
module parallel_to_serial_tx #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    parallel_to_serial_tx_if.slave  bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    shift_reg, hold_reg;
    logic [CW-1:0]   bit_cnt;
    logic            hold_full;
    logic            on_last, reload, accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // A reload edge is where the next frame (held or bypassed) gets picked up.
    always_comb begin
        on_last  = (state == SHIFT) && (bit_cnt == LAST);
        reload   = (state == IDLE) || on_last;
        accept   = bus.load_valid && !hold_full;
        state_nx = state;
        if (reload)
            state_nx = (hold_full || accept) ? SHIFT : IDLE;
    end

    always_comb begin
        bus.load_ready    = !hold_full;
        bus.svalid        = (state == SHIFT);
        bus.sdata         = bus.svalid && (LSB_FIRST ? shift_reg[0] : shift_reg[N-1]);
        bus.frame_start   = bus.svalid && (bit_cnt == '0);
        bus.frame_last    = on_last;
        bus.underrun_tick = on_last && !hold_full && !accept;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
        end else if (reload) begin
            // The held word always wins; load_ready is low then so nothing else competes.
            if (hold_full) begin
                shift_reg <= hold_reg;
                hold_full <= 1'b0;
                bit_cnt   <= '0;
            end else if (accept) begin
                shift_reg <= bus.load_data;
                bit_cnt   <= '0;
            end
        end else begin
            bit_cnt   <= bit_cnt + CW'(1);
            shift_reg <= LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
            if (accept) begin
                hold_reg  <= bus.load_data;
                hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Bench for parallel_to_serial_tx: constant vector table, directed corner sequences
// and random traffic against a word-level reference model.
module tb_parallel_to_serial_tx;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    parallel_to_serial_tx_if #(.N(8)) bus ();
    parallel_to_serial_tx_if #(.N(4)) bus4 ();

    parallel_to_serial_tx #(.N(8), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave));
    parallel_to_serial_tx #(.N(4), .LSB_FIRST(1'b0)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4.slave));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       sd, sv, fs, fl, ur, rdy;
    } vec_t;

    // Reference model: the word currently on the wire, its bit index, and the held words.
    int         m_idx;
    logic [7:0] m_cur;
    logic [7:0] m_held[$];

    task automatic model_reset();
        m_idx = -1;
        m_cur = '0;
        m_held.delete();
    endtask

    // Drive one cycle from the falling edge, compare against the model, advance the model.
    task automatic cyc(input logic v, input logic [7:0] d);
        logic e_sv, e_sd, e_rdy, acc, e_fs, e_fl, e_ur;
        bus.load_valid = v;
        bus.load_data  = d;
        #1;
        e_sv  = (m_idx >= 0);
        e_sd  = e_sv ? ((m_cur >> m_idx) & 8'd1) != 0 : 1'b0;
        e_rdy = (m_held.size() == 0);
        acc   = v && e_rdy;
        e_fs  = e_sv && (m_idx == 0);
        e_fl  = e_sv && (m_idx == N - 1);
        e_ur  = e_fl && e_rdy && !acc;
        check("svalid",        32'(bus.svalid),        32'(e_sv));
        check("sdata",         32'(bus.sdata),         32'(e_sd));
        check("load_ready",    32'(bus.load_ready),    32'(e_rdy));
        check("frame_start",   32'(bus.frame_start),   32'(e_fs));
        check("frame_last",    32'(bus.frame_last),    32'(e_fl));
        check("underrun_tick", 32'(bus.underrun_tick), 32'(e_ur));
        @(posedge clk);
        if (m_idx < 0 || m_idx == N - 1) begin
            if (m_held.size() != 0) begin
                m_cur = m_held.pop_front();
                m_idx = 0;
            end else if (acc) begin
                m_cur = d;
                m_idx = 0;
            end else begin
                m_idx = -1;
            end
        end else begin
            m_idx++;
            if (acc) m_held.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    vec_t vecs[10];
    logic [3:0] exp4;

    initial begin
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus4.load_valid = 1'b0;
        bus4.load_data  = '0;
        model_reset();

        // Reset state, with a handshake attempt that must not be captured.
        repeat (2) @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        check("rst.svalid",   32'(bus.svalid),        32'd0);
        check("rst.sdata",    32'(bus.sdata),         32'd0);
        check("rst.fstart",   32'(bus.frame_start),   32'd0);
        check("rst.flast",    32'(bus.frame_last),    32'd0);
        check("rst.underrun", 32'(bus.underrun_tick), 32'd0);
        check("rst.ready",    32'(bus.load_ready),    32'd1);
        bus.load_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // Single word 8'hA5 from idle: constant expected vectors.
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            bus.load_valid = vecs[i].v;
            bus.load_data  = vecs[i].d;
            #1;
            check($sformatf("vec%0d.sdata", i),    32'(bus.sdata),         32'(vecs[i].sd));
            check($sformatf("vec%0d.svalid", i),   32'(bus.svalid),        32'(vecs[i].sv));
            check($sformatf("vec%0d.fstart", i),   32'(bus.frame_start),   32'(vecs[i].fs));
            check($sformatf("vec%0d.flast", i),    32'(bus.frame_last),    32'(vecs[i].fl));
            check($sformatf("vec%0d.underrun", i), 32'(bus.underrun_tick), 32'(vecs[i].ur));
            check($sformatf("vec%0d.ready", i),    32'(bus.load_ready),    32'(vecs[i].rdy));
            @(posedge clk);
            @(negedge clk);
        end
        model_reset();

        // Back-to-back 01 then 80 with valid held high.
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h80);
        idle(18);

        // Bypass on the last bit of an FF frame.
        cyc(1'b1, 8'hFF);
        idle(7);
        cyc(1'b1, 8'h00);
        idle(10);

        // Back-pressure: 3C offered while hold is full, accepted once ready returns.
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'h3C);
        idle(26);

        // Random traffic with mixed valid densities.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 3) != 0) ^ (i >= 200), 8'($urandom));
        idle(20);

        // Reset mid-frame with a word held.
        cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'h55);
        idle(2);
        bus.load_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mrst.svalid",   32'(bus.svalid),        32'd0);
        check("mrst.sdata",    32'(bus.sdata),         32'd0);
        check("mrst.fstart",   32'(bus.frame_start),   32'd0);
        check("mrst.flast",    32'(bus.frame_last),    32'd0);
        check("mrst.underrun", 32'(bus.underrun_tick), 32'd0);
        check("mrst.ready",    32'(bus.load_ready),    32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 8'h0F);
        idle(12);

        // MSB-first, N=4: 4'b1100 emits 1,1,0,0.
        bus4.load_valid = 1'b1;
        bus4.load_data  = 4'b1100;
        @(posedge clk);
        @(negedge clk);
        bus4.load_valid = 1'b0;
        exp4 = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("n4.sdata%0d", i),  32'(bus4.sdata),      32'(exp4[3 - i]));
            check($sformatf("n4.svalid%0d", i), 32'(bus4.svalid),     32'd1);
            check($sformatf("n4.flast%0d", i),  32'(bus4.frame_last), 32'(i == 3));
            @(posedge clk);
            @(negedge clk);
        end
        check("n4.svalid_after", 32'(bus4.svalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
